// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable countdown timer with done flag and optional auto-reload.
module down_counter_timer #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     load_i,
    input  logic [COUNTER_WIDTH-1:0] load_value_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     decrement_i,
    input  logic                     auto_reload_i,
    output logic [COUNTER_WIDTH-1:0] counter_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     expire_o
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t state_q, state_d;
    logic [COUNTER_WIDTH-1:0] reload_q, reload_d, count_d;
    logic expire_d;
    logic last;
    assign last = counter_o == COUNTER_WIDTH'(1);
    assign busy_o = (state_q == RUN) || (state_q == PAUSE);
    assign done_o = state_q == DONE;
    always_comb begin
        state_d = state_q;
        count_d = counter_o;
        reload_d = reload_q;
        expire_d = 1'b0;
        if (load_i) begin
            count_d = load_value_i;
            reload_d = load_value_i;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (!stop_i && start_i && counter_o != '0) state_d = RUN;
                RUN: begin
                    if (stop_i) begin
                        state_d = PAUSE;
                    end else if (decrement_i && last) begin
                        expire_d = 1'b1;
                        state_d = auto_reload_i ? RUN : DONE;
                        count_d = auto_reload_i ? reload_q : '0;
                    end else if (decrement_i && counter_o != '0) begin
                        count_d = counter_o - 1'b1;
                    end
                end
                PAUSE: if (!stop_i && start_i) state_d = RUN;
                DONE: begin
                    if (stop_i) begin
                        state_d = IDLE;
                    end else if (start_i && reload_q != '0) begin
                        state_d = RUN;
                        count_d = reload_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            counter_o <= '0;
            reload_q <= '0;
            expire_o <= 1'b0;
        end else begin
            state_q <= state_d;
            counter_o <= count_d;
            reload_q <= reload_d;
            expire_o <= expire_d;
        end
    end
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: scoreboard-driven checks of the countdown timer.
module tb_down_counter_timer;
    localparam int W = 16;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic load_i = 1'b0;
    logic [W-1:0] load_value_i = '0;
    logic start_i = 1'b0;
    logic stop_i = 1'b0;
    logic decrement_i = 1'b0;
    logic auto_reload_i = 1'b0;
    logic [W-1:0] counter_o;
    logic busy_o, done_o, expire_o;
    int total = 0;
    int bad = 0;
    typedef struct packed {
        logic r, ld;
        logic [W-1:0] lv;
        logic st, sp, dec, ar;
    } stim_t;
    typedef struct packed {
        logic [W-1:0] cnt;
        logic busy, done, xp;
    } obs_t;
    stim_t stim_q[$];
    obs_t exp_q[$];
    down_counter_timer #(.COUNTER_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .load_i(load_i), .load_value_i(load_value_i),
        .start_i(start_i), .stop_i(stop_i), .decrement_i(decrement_i),
        .auto_reload_i(auto_reload_i), .counter_o(counter_o), .busy_o(busy_o),
        .done_o(done_o), .expire_o(expire_o)
    );
    always #5 CLK = ~CLK;
    task automatic plan(input logic r, ld, input logic [W-1:0] lv, input logic st, sp, dec, ar,
                        input logic [W-1:0] c, input logic b, d, x);
        stim_t s;
        obs_t e;
        s = '{r, ld, lv, st, sp, dec, ar};
        e = '{c, b, d, x};
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask
    task automatic cyc(input stim_t s);
        {RST, load_i, load_value_i, start_i, stop_i, decrement_i, auto_reload_i} = s;
        @(posedge CLK);
        #1;
    endtask
    task automatic test_reset();
        int n = 0;
        obs_t e, o;
        plan(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        plan(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            o = {counter_o, busy_o, done_o, expire_o};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset[%0d]: got cnt=%0h busy=%b done=%b exp=%b want cnt=%0h busy=%b done=%b exp=%b", n, o.cnt, o.busy, o.done, o.xp, e.cnt, e.busy, e.done, e.xp);
            end
            n++;
        end
    endtask
    task automatic test_count();
        int n = 0;
        obs_t e, o;
        plan(0, 1, 3, 0, 0, 0, 0, 3, 0, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        plan(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            o = {counter_o, busy_o, done_o, expire_o};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL count[%0d]: got cnt=%0h busy=%b done=%b exp=%b want cnt=%0h busy=%b done=%b exp=%b", n, o.cnt, o.busy, o.done, o.xp, e.cnt, e.busy, e.done, e.xp);
            end
            n++;
        end
    endtask
    task automatic test_done_restart();
        int n = 0;
        obs_t e, o;
        plan(0, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        plan(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        plan(0, 1, 4, 0, 0, 0, 0, 4, 0, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 0, 4, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        plan(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            o = {counter_o, busy_o, done_o, expire_o};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL done_restart[%0d]: got cnt=%0h busy=%b done=%b exp=%b want cnt=%0h busy=%b done=%b exp=%b", n, o.cnt, o.busy, o.done, o.xp, e.cnt, e.busy, e.done, e.xp);
            end
            n++;
        end
    endtask
    task automatic test_auto_reload();
        int n = 0;
        obs_t e, o;
        plan(0, 1, 2, 0, 0, 0, 1, 2, 0, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 1, 2, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            plan(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0);
            plan(0, 0, 0, 0, 0, 1, 1, 2, 1, 0, 1);
        end
        plan(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) plan(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1);
        plan(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            o = {counter_o, busy_o, done_o, expire_o};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL auto_reload[%0d]: got cnt=%0h busy=%b done=%b exp=%b want cnt=%0h busy=%b done=%b exp=%b", n, o.cnt, o.busy, o.done, o.xp, e.cnt, e.busy, e.done, e.xp);
            end
            n++;
        end
    endtask
    task automatic test_pause();
        int n = 0;
        obs_t e, o;
        plan(0, 1, 5, 0, 0, 0, 0, 5, 0, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 0, 5, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 4, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0);
        plan(0, 0, 0, 0, 1, 1, 0, 3, 1, 0, 0);
        for (int i = 0; i < 4; i++) plan(0, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0);
        plan(0, 0, 0, 1, 1, 0, 0, 3, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 3, 1, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        plan(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            o = {counter_o, busy_o, done_o, expire_o};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL pause[%0d]: got cnt=%0h busy=%b done=%b exp=%b want cnt=%0h busy=%b done=%b exp=%b", n, o.cnt, o.busy, o.done, o.xp, e.cnt, e.busy, e.done, e.xp);
            end
            n++;
        end
    endtask
    task automatic test_priority();
        int n = 0;
        obs_t e, o;
        plan(0, 1, 2, 0, 0, 0, 0, 2, 0, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 0, 2, 1, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        plan(0, 1, 7, 0, 0, 1, 0, 7, 0, 0, 0);
        plan(0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
        plan(0, 0, 0, 0, 1, 0, 0, 7, 0, 0, 0);
        plan(0, 0, 0, 1, 1, 0, 0, 7, 0, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 0, 7, 1, 0, 0);
        plan(0, 1, 9, 1, 0, 1, 0, 9, 0, 0, 0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            o = {counter_o, busy_o, done_o, expire_o};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL priority[%0d]: got cnt=%0h busy=%b done=%b exp=%b want cnt=%0h busy=%b done=%b exp=%b", n, o.cnt, o.busy, o.done, o.xp, e.cnt, e.busy, e.done, e.xp);
            end
            n++;
        end
    endtask
    task automatic test_reset_mid_run();
        int n = 0;
        obs_t e, o;
        plan(0, 1, 16'hFFFF, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 0, 16'hFFFF, 1, 0, 0);
        for (int i = 1; i <= 10; i++) plan(0, 0, 0, 0, 0, 1, 0, W'(32'hFFFF - i), 1, 0, 0);
        plan(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        plan(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        plan(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        plan(0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        plan(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        plan(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            o = {counter_o, busy_o, done_o, expire_o};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_mid_run[%0d]: got cnt=%0h busy=%b done=%b exp=%b want cnt=%0h busy=%b done=%b exp=%b", n, o.cnt, o.busy, o.done, o.xp, e.cnt, e.busy, e.done, e.xp);
            end
            n++;
        end
    endtask
    initial begin
        test_reset();
        test_count();
        test_done_restart();
        test_auto_reload();
        test_pause();
        test_priority();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter / countdown timer. It is the decrementing counterpart of the team's up-counter.
- Software or a controller loads a terminal count and starts the timer. Each qualified tick (`decrement_i`) decrements the count.
- On reaching zero it either stops and flags done, or auto-reloads and keeps running.
- Used for timeouts, delay generation and periodic event generation in the SoC peripheral subsystem.

Parameters:
- COUNTER_WIDTH, 16: width of count, load value and reload register; must be >= 2.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- load_i  input  1  load strobe; counter_o and reload register take load_value_i.
- load_value_i  input  COUNTER_WIDTH  value captured on load_i.
- start_i  input  1  start or resume request.
- stop_i  input  1  pause request (RUN) or clear request (DONE).
- decrement_i  input  1  tick enable; decrement by one when in RUN.
- auto_reload_i  input  1  level; when 1, expiry reloads instead of stopping.
- counter_o  output  COUNTER_WIDTH  current count, registered.
- busy_o  output  1  high in RUN or PAUSE.
- done_o  output  1  high while in DONE.
- expire_o  output  1  one-cycle pulse, registered, for each expiry.

Behaviour:
- RST=1 sampled at a CLK edge sets:
  - state = IDLE; counter_o = 0; reload register = 0
  - busy_o = 0, done_o = 0, expire_o = 0
  - RST mid-RUN aborts with no expire_o pulse.
- States: IDLE, RUN, PAUSE, DONE. 2-bit encoding; internal only.
- Priority per cycle: RST > load_i > stop_i > start_i > decrement_i.
- load_i, any state:
  - counter_o and reload register take load_value_i; state -> IDLE.
  - expire_o stays 0 that cycle; a concurrent decrement is discarded.
- IDLE:
  - start_i with counter_o != 0 -> RUN.
  - start_i with counter_o == 0 is ignored (stay IDLE).
  - stop_i has no effect; decrement_i is ignored.
- RUN, decrement_i=1:
  - counter_o > 1: counter_o <= counter_o - 1.
  - counter_o == 1 and auto_reload_i=0: counter_o <= 0, state -> DONE, expire_o = 1 for the next cycle.
  - counter_o == 1 and auto_reload_i=1: counter_o <= reload register, stay RUN, expire_o = 1 for the next cycle.
  - With reload value 1, expire_o pulses after every tick.
- RUN, decrement_i=0: hold.
- RUN, stop_i -> PAUSE; counter held; the same-cycle decrement is discarded.
- PAUSE:
  - start_i -> RUN.
  - decrement_i ignored; stop_i has no effect.
- DONE:
  - counter_o = 0, done_o = 1.
  - stop_i -> IDLE.
  - start_i: if reload register != 0, counter_o <= reload register and state -> RUN (restart); else ignored.
  - decrement_i ignored.
- start_i and stop_i together: stop_i wins.
- Timing and arithmetic:
  - expire_o is asserted in the same cycle that counter_o first shows 0 or the reload value, and deasserts the following cycle unless another expiry occurs.
  - counter_o never wraps below 0; decrementing from 0 is impossible by construction.
  - Output latency: all outputs update one cycle after the causing input edge; no combinational input-to-output paths.

Test Plan:
- Reset and count:
  - RST for 2 cycles -> counter_o=0, busy_o=0, done_o=0, expire_o=0.
  - load_value_i=3, load_i, start_i, then decrement_i held high -> counter_o 3,2,1,0.
  - expire_o high exactly in the cycle counter_o=0; done_o=1 and busy_o=0 from then on.
- Auto-reload:
  - load 2, auto_reload_i=1, start, decrement_i continuous for 6 cycles -> counter_o 2,1,2,1,2,1,2.
  - expire_o pulses 3 times, each coinciding with counter_o showing 2; done_o stays 0.
- Pause and resume:
  - load 5, start, 2 ticks (counter_o=3), then stop_i together with decrement_i -> counter_o stays 3 in PAUSE; busy_o=1.
  - 4 further ticks -> counter_o stays 3.
  - start_i, then 3 ticks -> counter_o=0, expire_o one pulse.
- Priority and corner cases:
  - In RUN with counter_o=1, assert load_i (value 7) with decrement_i -> counter_o=7, state IDLE, no expire_o.
  - start_i with counter_o=0 after reset -> stays IDLE, busy_o=0.
- DONE restart and clear:
  - From DONE after load 4, start_i -> counter_o=4, busy_o=1, done_o=0.
  - Run to DONE, then stop_i -> IDLE, done_o=0, counter_o=0.
- Reset mid-run:
  - load 0xFFFF, start, 10 ticks, then RST with decrement_i and stop_i both high -> all outputs return to reset values next cycle, no expire_o pulse.
